uart_aes_block_loader: RTL

Controller sitting between the UART receiver and the AES-128 core. It edge-detects the receiver's RxDone, parses a one-byte command, assembles the next 16 received bytes into a 128-bit key or data block, and presents data blocks to the AES core with a valid/ready handshake. It also gates the receiver with RxEn, drives its NBits configuration, and flags protocol errors and inter-byte timeouts.

---
 rtl/uart_aes_block_loader_if.sv | 32 +++
 rtl/uart_aes_block_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_aes_block_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_aes_block_loader_if
//  Description : Bundle of the receiver-side, key/data-side and status signals
//                of the UART-to-AES block loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_aes_block_loader_if;
    logic [7:0]   RxData;
    logic         RxDone;
    logic         RxEn;
    logic [3:0]   NBits;
    logic [127:0] Key;
    logic         KeyValid;
    logic [127:0] DataOut;
    logic         DataValid;
    logic         DataReady;
    logic         Busy;
    logic         Err;
    logic [1:0]   ErrCode;

    // master: the loader itself; slave: receiver / AES core / monitor side
    modport master (
        input  RxData, RxDone, DataReady,
        output RxEn, NBits, Key, KeyValid, DataOut, DataValid, Busy, Err, ErrCode
    );
    modport slave (
        output RxData, RxDone, DataReady,
        input  RxEn, NBits, Key, KeyValid, DataOut, DataValid, Busy, Err, ErrCode
    );
endinterface
`default_nettype wire

// File: rtl/uart_aes_block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_aes_block_loader
//  Description : Parses K/D command frames from a UART receiver, assembles
//                16-byte key or data blocks and hands data blocks to AES.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_aes_block_loader #(
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic [7:0]  CMD_KEY  = 8'h4B,
    parameter logic [7:0]  CMD_DATA = 8'h44
) (
    input  logic                           Clk,
    input  logic                           Rst,
    uart_aes_block_loader_if.master        bus
);

    localparam int unsigned c_timer_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 2);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_KEY     = 2'd0,
        MODE_DATA    = 2'd1,
        MODE_DISCARD = 2'd2
    } mode_t;

    state_t                 r_state;
    state_t                 w_state_next;
    mode_t                  r_mode;
    mode_t                  w_mode_next;

    logic                   r_d1;
    logic                   r_d2;
    logic [3:0]             r_cnt;
    logic [c_timer_w-1:0]   r_timer;
    logic [119:0]           r_sr;
    logic [127:0]           r_key;
    logic                   r_key_valid;
    logic [127:0]           r_data_out;
    logic                   r_data_valid;
    logic                   r_err;
    logic [1:0]             r_err_code;

    logic                   w_strobe;
    logic                   w_load_start;
    logic                   w_byte;
    logic                   w_frame_done;
    logic                   w_timeout;
    logic                   w_accept;
    logic                   w_err;
    logic [1:0]             w_err_code;

    assign w_strobe = r_d1 & ~r_d2;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_load_start = 1'b0;
        w_byte       = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        w_err_code   = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    if (bus.RxData == CMD_KEY) begin
                        w_state_next = ST_LOAD;
                        w_mode_next  = MODE_KEY;
                        w_load_start = 1'b1;
                    end else if (bus.RxData == CMD_DATA) begin
                        w_state_next = ST_LOAD;
                        w_load_start = 1'b1;
                        if (r_key_valid) begin
                            w_mode_next = MODE_DATA;
                        end else begin
                            w_mode_next = MODE_DISCARD;
                            w_err       = 1'b1;
                            w_err_code  = 2'd3;
                        end
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 2'd1;
                    end
                end
            end
            ST_LOAD: begin
                // A strobe always beats a coincident timeout
                if (w_strobe) begin
                    w_byte = 1'b1;
                    if (r_cnt == 4'd15) begin
                        w_frame_done = 1'b1;
                        w_state_next = (r_mode == MODE_DATA) ? ST_PRESENT : ST_IDLE;
                    end
                end else if (r_timer == c_timer_last) begin
                    // timer would reach TIMEOUT-1 on this edge
                    w_timeout    = 1'b1;
                    w_err        = 1'b1;
                    w_err_code   = 2'd2;
                    w_state_next = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (r_data_valid && bus.DataReady) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_d1         <= 1'b0;
            r_d2         <= 1'b0;
            r_mode       <= MODE_KEY;
            r_cnt        <= 4'd0;
            r_timer      <= '0;
            r_sr         <= '0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_d1  <= bus.RxDone;
            r_d2  <= r_d1;
            r_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end

            if (w_load_start) begin
                r_mode  <= w_mode_next;
                r_cnt   <= 4'd0;
                r_timer <= '0;
            end

            // cnt wraps 15 -> 0 on the final byte, so completion clears it
            if (w_byte) begin
                r_sr    <= {r_sr[111:0], bus.RxData};
                r_cnt   <= r_cnt + 4'd1;
                r_timer <= '0;
            end else if (w_timeout) begin
                r_cnt   <= 4'd0;
                r_timer <= '0;
            end else if (r_state == ST_LOAD) begin
                r_timer <= r_timer + c_timer_one;
            end

            if (w_frame_done) begin
                case (r_mode)
                    MODE_KEY: begin
                        r_key       <= {r_sr, bus.RxData};
                        r_key_valid <= 1'b1;
                    end
                    MODE_DATA: begin
                        r_data_out   <= {r_sr, bus.RxData};
                        r_data_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            if (w_accept) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign bus.RxEn      = (r_state != ST_PRESENT);
    assign bus.Busy      = (r_state != ST_IDLE);
    assign bus.NBits     = 4'd8;
    assign bus.Key       = r_key;
    assign bus.KeyValid  = r_key_valid;
    assign bus.DataOut   = r_data_out;
    assign bus.DataValid = r_data_valid;
    assign bus.Err       = r_err;
    assign bus.ErrCode   = r_err_code;

endmodule
`default_nettype wire
